// File: rtl/tdc_therm_stim.sv
// tdc_therm_stim: command-driven thermometer-code stimulus for the ones-counter; TDC_BUBBLE_EN adds bubble injection.
module tdc_therm_stim #(
  parameter int WIDTH = 90,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [CW-1:0]    cmd_start,
  input  logic [CW-1:0]    cmd_stop,
  input  logic [CW-1:0]    cmd_hold,
  input  logic             abort,
`ifdef TDC_BUBBLE_EN
  input  logic             bubble_en,
  input  logic [6:0]       bubble_pos,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [CW-1:0]    Q_cnt,
  output logic             Q_valid,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SINGLE, SWEEP} state_t;
  state_t st, st_n;
  logic [CW-1:0] stop_r, hold_r, hcnt, stop_n, hold_n, hcnt_n, code_n, s_c, e_c, h_c;
  logic dn, dn_n, done_n, valid_n;
  logic [WIDTH-1:0] bub;
  function automatic logic [WIDTH-1:0] therm(input logic [CW-1:0] k);
    logic [WIDTH-1:0] t;
    for (int i = 0; i < WIDTH; i++) t[i] = CW'(i) < k;
    return t;
  endfunction
  assign cmd_ready = st == IDLE;
  assign s_c = cmd_start > CW'(WIDTH) ? CW'(WIDTH) : cmd_start;
  assign e_c = cmd_stop > CW'(WIDTH) ? CW'(WIDTH) : cmd_stop;
  assign h_c = cmd_hold == '0 ? CW'(1) : cmd_hold;
`ifdef TDC_BUBBLE_EN
  assign bub = (bubble_en && bubble_pos < 7'(WIDTH)) ? {{(WIDTH-1){1'b0}}, 1'b1} << bubble_pos : '0;
`else
  assign bub = '0;
`endif
  always_comb begin
    st_n = st;
    code_n = Q_cnt;
    stop_n = stop_r;
    hold_n = hold_r;
    hcnt_n = hcnt;
    dn_n = dn;
    done_n = 1'b0;
    if (st == IDLE) begin
      if (cmd_valid && !abort) begin
        st_n = cmd_mode ? SWEEP : SINGLE;
        code_n = s_c;
        stop_n = e_c;
        dn_n = e_c < s_c;
        hold_n = h_c;
        hcnt_n = h_c - CW'(1);
      end
    end else if (abort) begin
      st_n = IDLE;
      code_n = '0;
    end else if (hcnt != '0) begin
      hcnt_n = hcnt - CW'(1);
    end else if (st == SINGLE || Q_cnt == stop_r) begin
      st_n = IDLE;
      code_n = '0;
      done_n = 1'b1;
    end else begin
      code_n = dn ? Q_cnt - CW'(1) : Q_cnt + CW'(1);
      hcnt_n = hold_r - CW'(1);
    end
    valid_n = st_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      Q <= '0;
      Q_cnt <= '0;
      Q_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      stop_r <= '0;
      hold_r <= '0;
      hcnt <= '0;
      dn <= 1'b0;
    end else begin
      st <= st_n;
      Q <= valid_n ? therm(code_n) ^ bub : '0;
      Q_cnt <= code_n;
      Q_valid <= valid_n;
      busy <= valid_n;
      done <= done_n;
      stop_r <= stop_n;
      hold_r <= hold_n;
      hcnt <= hcnt_n;
      dn <= dn_n;
    end
  end
endmodule

// File: tb/tb_tdc_therm_stim.sv
// tb_tdc_therm_stim: table-driven bench for tdc_therm_stim; exercises bubbles when TDC_BUBBLE_EN is defined.
module tb_tdc_therm_stim;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_mode = 0, abort = 0;
  logic cmd_ready, Q_valid, busy, done;
  logic [7:0] cmd_start = 0, cmd_stop = 0, cmd_hold = 0, Q_cnt;
  logic [89:0] Q;
`ifdef TDC_BUBBLE_EN
  logic bubble_en = 0;
  logic [6:0] bubble_pos = 0;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  tdc_therm_stim dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_hold(cmd_hold), .abort(abort),
`ifdef TDC_BUBBLE_EN
    .bubble_en(bubble_en), .bubble_pos(bubble_pos),
`endif
    .Q(Q), .Q_cnt(Q_cnt), .Q_valid(Q_valid), .busy(busy), .done(done)
  );
  typedef struct {
    logic m; int s, e, h, f, l, eh, n;
  } vec_t;
  vec_t tbl[7];
  function automatic logic [89:0] therm(input int k);
    logic [89:0] ones = '1;
    return k == 0 ? '0 : ones >> (90 - k);
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic m, input int s, input int e, input int h, input logic ab);
    @(negedge clk);
    cmd_valid = 1; cmd_mode = m; cmd_start = 8'(s); cmd_stop = 8'(e); cmd_hold = 8'(h); abort = ab;
    tick();
    cmd_valid = 0; abort = 0;
  endtask
  task automatic run(input vec_t v);
    int n = 0, code, dir;
    dir = v.l >= v.f ? 1 : -1;
    issue(v.m, v.s, v.e, v.h, 0);
    chk("latency_valid", 128'(Q_valid), 128'(1));
    while (Q_valid && n < 300) begin
      code = v.f + dir * (n / v.eh);
      chk("q_cnt", 128'(Q_cnt), 128'(code));
      chk("q_therm", 128'(Q), 128'(therm(code)));
      chk("busy_rdy", {busy, cmd_ready, done}, 128'(3'b100));
      n++;
      tick();
    end
    chk("valid_cycles", 128'(n), 128'(v.n));
    chk("done_cycle", {done, Q_valid, busy, cmd_ready}, 128'(4'b1001));
    chk("done_zero", {Q, Q_cnt}, 128'(0));
  endtask
  initial begin
    tbl[0] = '{0, 0, 0, 1, 0, 0, 1, 1};
    tbl[1] = '{0, 45, 0, 3, 45, 45, 3, 3};
    tbl[2] = '{1, 0, 90, 0, 0, 90, 1, 91};
    tbl[3] = '{1, 10, 7, 2, 10, 7, 2, 8};
    tbl[4] = '{0, 200, 0, 1, 90, 90, 1, 1};
    tbl[5] = '{1, 5, 5, 2, 5, 5, 2, 2};
    tbl[6] = '{1, 95, 88, 1, 90, 88, 1, 3};
    cmd_valid = 1; cmd_start = 8'd30;
    tick(); tick();
    chk("reset_state", {Q, Q_cnt, Q_valid, busy, done}, 128'(0));
    chk("reset_ready", 128'(cmd_ready), 128'(1));
    cmd_valid = 0;
    @(negedge clk) rst = 0;
    tick();
    chk("reset_cmd_ignored", 128'(Q_valid), 128'(0));
    for (int i = 0; i < 7; i++) run(tbl[i]);
    tick();
    chk("done_one_cycle", 128'(done), 128'(0));
    run(tbl[1]);
    run(tbl[3]);
    issue(1, 0, 90, 1, 0);
    for (int i = 0; i < 19; i++) tick();
    chk("pre_abort_cnt", 128'(Q_cnt), 128'(19));
    @(negedge clk) abort = 1;
    tick();
    abort = 0;
    chk("abort_out", {Q, Q_cnt, Q_valid, busy, done}, 128'(0));
    tick();
    chk("abort_no_done", {done, Q_valid}, 128'(0));
    issue(1, 0, 90, 1, 0);
    for (int i = 0; i < 19; i++) tick();
    @(negedge clk) rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_out", {Q, Q_cnt, Q_valid, busy, done}, 128'(0));
    tick();
    chk("rst_mid_no_done", {done, Q_valid}, 128'(0));
    issue(0, 30, 0, 1, 1);
    chk("abort_accept_drop", {Q_valid, busy, cmd_ready}, 128'(3'b001));
    tick();
    chk("abort_accept_drop2", {Q_valid, done}, 128'(0));
    @(negedge clk) abort = 1;
    tick();
    abort = 0;
    chk("abort_idle", {Q_valid, cmd_ready}, 128'(2'b01));
`ifdef TDC_BUBBLE_EN
    bubble_en = 1; bubble_pos = 7'd20;
    issue(0, 30, 0, 1, 0);
    chk("bubble_q", 128'(Q), 128'(therm(30) ^ (90'd1 << 20)));
    chk("bubble_cnt", 128'(Q_cnt), 128'(30));
    tick();
    chk("bubble_idle", 128'(Q), 128'(0));
    bubble_pos = 7'd100;
    issue(0, 30, 0, 1, 0);
    chk("bubble_out_of_range", 128'(Q), 128'(therm(30)));
    tick();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
